// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: the FSM state encoding, the frame width and the
// reset levels of the input synchronizers.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    localparam int SPI_BITS = 8;
    localparam int CNT_W    = $clog2(SPI_BITS + 1);

    localparam logic SCK_RST  = 1'b0;
    localparam logic CS_N_RST = 1'b1;
    localparam logic MOSI_RST = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI line, followed by a
// rise/fall detector built from the last stage and one extra delay flop.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              dly_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= {STAGES{RST_VAL}};
            dly_reg  <= RST_VAL;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
            dly_reg  <= sync_reg[STAGES-1];
        end
    end

    assign level = sync_reg[STAGES-1];
    assign rise  = level & ~dly_reg;
    assign fall  = ~level & dly_reg;

endmodule

// File: rtl/spi_slave.sv
// SPI Mode 0 slave (MSB first, 8-bit frames, back-to-back bytes per CS) with a
// single-entry transmit holding register, oversampled on the system clock.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spi_sck,
    input  logic                spi_cs_n,
    input  logic                spi_mosi,
    output logic                spi_miso,
    output logic                spi_miso_oe,
    input  logic [SPI_BITS-1:0] tx_byte,
    input  logic                tx_load,
    output logic                tx_ready,
    output logic [SPI_BITS-1:0] rx_byte,
    output logic                rx_valid,
    output logic                tx_underrun,
    output logic                busy
);

    logic sck_level, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SCK_RST)) u_sync_sck (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_sck),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CS_N_RST)) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(MOSI_RST)) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_mosi),
        .level (mosi_level),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    // Only edges of sck/cs and the level of mosi are consumed.
    assign unused_sync = &{1'b0, sck_level, cs_level, mosi_rise, mosi_fall};

    spi_state_t          state_reg, state_next;
    logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [SPI_BITS-1:0] shift_tx_reg, shift_tx_next;
    logic [SPI_BITS-1:0] shift_rx_reg, shift_rx_next;
    logic [SPI_BITS-1:0] hold_reg, hold_next;
    logic                hold_full_reg, hold_full_next;
    logic [SPI_BITS-1:0] rx_byte_reg, rx_byte_next;
    logic                rx_valid_reg, rx_valid_next;
    logic                underrun_reg, underrun_next;
    logic                load_tx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            shift_tx_reg  <= '0;
            shift_rx_reg  <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            rx_byte_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_tx_reg  <= shift_tx_next;
            shift_rx_reg  <= shift_rx_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            rx_byte_reg   <= rx_byte_next;
            rx_valid_reg  <= rx_valid_next;
            underrun_reg  <= underrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_tx_next  = shift_tx_reg;
        shift_rx_next  = shift_rx_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        rx_byte_next   = rx_byte_reg;
        rx_valid_next  = 1'b0;
        underrun_next  = 1'b0;
        load_tx        = 1'b0;

        // A load is only accepted into an empty register, so it can never
        // collide with a consume, which needs a full one.
        if (tx_load && !hold_full_reg) begin
            hold_next      = tx_byte;
            hold_full_next = 1'b1;
        end

        unique case (state_reg)
            IDLE: begin
                if (cs_fall) begin
                    state_next   = ACTIVE;
                    bit_cnt_next = '0;
                    load_tx      = 1'b1;
                end
            end
            ACTIVE: begin
                // CS release wins over any sck edge seen in the same cycle.
                if (cs_rise) begin
                    state_next   = IDLE;
                    bit_cnt_next = '0;
                end else if (sck_rise) begin
                    shift_rx_next = {shift_rx_reg[SPI_BITS-2:0], mosi_level};
                    bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
                    if (bit_cnt_reg == CNT_W'(SPI_BITS - 1)) begin
                        rx_byte_next  = {shift_rx_reg[SPI_BITS-2:0], mosi_level};
                        rx_valid_next = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_reg == CNT_W'(SPI_BITS)) begin
                        bit_cnt_next = '0;
                        load_tx      = 1'b1;
                    end else begin
                        shift_tx_next = {shift_tx_reg[SPI_BITS-2:0], 1'b0};
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (load_tx) begin
            if (hold_full_reg) begin
                shift_tx_next  = hold_reg;
                hold_full_next = 1'b0;
            end else begin
                shift_tx_next = '0;
                underrun_next = 1'b1;
            end
        end
    end

    assign busy        = (state_reg == ACTIVE);
    assign spi_miso    = busy & shift_tx_reg[SPI_BITS-1];
    assign spi_miso_oe = busy;
    assign tx_ready    = ~hold_full_reg;
    assign rx_byte     = rx_byte_reg;
    assign rx_valid    = rx_valid_reg;
    assign tx_underrun = underrun_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged Mode 0 master plus a per-cycle
// checker driven by a queue of expected received bytes and a CS latency model.
module tb_spi_slave;

    localparam int SS = 2;
    localparam int H  = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sck = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_byte;
    logic       rx_valid, tx_underrun, busy;

    spi_slave #(.SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .tx_byte     (tx_byte),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int rxv_cnt = 0;
    int ufl_cnt = 0;
    logic [7:0]  exp_rx_q[$];
    logic [7:0]  model_rx = 8'h00;
    logic [15:0] cs_hist = '1;
    logic        model_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The slave follows the master's chip select SS+1 clocks later.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_rx = 8'h00;
            exp_rx_q.delete();
            cs_hist  = '1;
        end else begin
            cs_hist    = {cs_hist[14:0], spi_cs_n};
            model_busy = ~cs_hist[SS+1];
            if (rx_valid) begin
                rxv_cnt++;
                if (exp_rx_q.size() == 0) check("rx_valid_unexpected", 32'(rx_valid), 32'd0);
                else model_rx = exp_rx_q.pop_front();
            end
            if (tx_underrun) ufl_cnt++;
            check("rx_byte", 32'(rx_byte), 32'(model_rx));
            check("busy", 32'(busy), 32'(model_busy));
            check("miso_oe", 32'(spi_miso_oe), 32'(model_busy));
            if (!model_busy) check("miso_idle", 32'(spi_miso), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        tx_byte = v;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    // Shifts nbits of mo out MSB first; with end_frame the final sck fall and
    // the CS release happen together so no extra slot reload is triggered.
    task automatic frame_bits(input logic [7:0] mo, input int nbits, input bit end_frame,
                              output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = mo[i];
            tick(H);
            mi[i]   = spi_miso;
            spi_sck = 1'b1;
            tick(H);
            spi_sck = 1'b0;
            if (end_frame && i == 8 - nbits) spi_cs_n = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_rx_byte"}, 32'(rx_byte), 32'h00);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_underrun"}, 32'(tx_underrun), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_miso"}, 32'(spi_miso), 32'd0);
        check({tag, "_miso_oe"}, 32'(spi_miso_oe), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m1, m2;

        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(4);

        // Single byte with a preloaded response.
        load(8'hA5);
        check("preload_tx_ready", 32'(tx_ready), 32'd0);
        rxv_cnt = 0; ufl_cnt = 0;
        exp_rx_q.push_back(8'h3C);
        spi_cs_n = 1'b0;
        frame_bits(8'h3C, 8, 1'b1, m1);
        tick(SS + 4);
        $display("single: master got %02h, rx_byte %02h", m1, rx_byte);
        check("single_miso_byte", 32'(m1), 32'hA5);
        check("single_rx_byte", 32'(rx_byte), 32'h3C);
        check("single_rx_valid_cnt", 32'(rxv_cnt), 32'd1);
        check("single_underrun_cnt", 32'(ufl_cnt), 32'd0);
        check("single_tx_ready", 32'(tx_ready), 32'd1);

        // Two bytes in one chip-select window, second response loaded on the fly.
        load(8'h11);
        rxv_cnt = 0; ufl_cnt = 0;
        exp_rx_q.push_back(8'hF0);
        exp_rx_q.push_back(8'h0F);
        fork
            begin
                spi_cs_n = 1'b0;
                frame_bits(8'hF0, 8, 1'b0, m1);
                frame_bits(8'h0F, 8, 1'b1, m2);
            end
            begin
                for (int t = 0; t < 40 && !tx_ready; t++) tick(1);
                check("dual_tx_ready_rise", 32'(tx_ready), 32'd1);
                load(8'h22);
            end
        join
        tick(SS + 4);
        $display("dual: master got %02h %02h, rx_byte %02h", m1, m2, rx_byte);
        check("dual_miso_byte0", 32'(m1), 32'h11);
        check("dual_miso_byte1", 32'(m2), 32'h22);
        check("dual_rx_valid_cnt", 32'(rxv_cnt), 32'd2);
        check("dual_underrun_cnt", 32'(ufl_cnt), 32'd0);
        check("dual_queue_drained", 32'(exp_rx_q.size()), 32'd0);

        // No preload: zero is sent and one underrun is flagged.
        check("underrun_tx_ready", 32'(tx_ready), 32'd1);
        rxv_cnt = 0; ufl_cnt = 0;
        exp_rx_q.push_back(8'h55);
        spi_cs_n = 1'b0;
        frame_bits(8'h55, 8, 1'b1, m1);
        tick(SS + 4);
        $display("underrun: master got %02h, rx_byte %02h, underruns %0d", m1, rx_byte, ufl_cnt);
        check("underrun_miso_byte", 32'(m1), 32'h00);
        check("underrun_cnt", 32'(ufl_cnt), 32'd1);
        check("underrun_rx_byte", 32'(rx_byte), 32'h55);

        // Chip select released after five bits: partial byte dropped.
        load(8'hC3);
        rxv_cnt = 0; ufl_cnt = 0;
        spi_cs_n = 1'b0;
        frame_bits(8'hAA, 5, 1'b0, m1);
        tick(H);
        spi_cs_n = 1'b1;
        tick(SS + 2);
        $display("abort: busy %0b oe %0b rx_byte %02h", busy, spi_miso_oe, rx_byte);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_miso_oe", 32'(spi_miso_oe), 32'd0);
        check("abort_rx_byte", 32'(rx_byte), 32'h55);
        check("abort_rx_valid_cnt", 32'(rxv_cnt), 32'd0);
        check("abort_underrun_cnt", 32'(ufl_cnt), 32'd0);
        tick(4);

        // A load while the holding register is full is dropped.
        load(8'h5A);
        check("ignore_tx_ready", 32'(tx_ready), 32'd0);
        load(8'h99);
        rxv_cnt = 0; ufl_cnt = 0;
        exp_rx_q.push_back(8'h81);
        spi_cs_n = 1'b0;
        frame_bits(8'h81, 8, 1'b1, m1);
        tick(SS + 4);
        $display("ignore: master got %02h, rx_byte %02h", m1, rx_byte);
        check("ignore_miso_byte", 32'(m1), 32'h5A);
        check("ignore_rx_byte", 32'(rx_byte), 32'h81);
        check("ignore_tx_ready_after", 32'(tx_ready), 32'd1);
        check("ignore_underrun_cnt", 32'(ufl_cnt), 32'd0);

        // Reset pulse in the middle of a byte.
        load(8'h77);
        rxv_cnt = 0; ufl_cnt = 0;
        spi_cs_n = 1'b0;
        frame_bits(8'hE7, 3, 1'b0, m1);
        tick(2);
        rst_n    = 1'b0;
        spi_cs_n = 1'b1;
        tick(1);
        rst_n = 1'b1;
        check_reset_outputs("midreset");
        for (int k = 0; k < 4; k++) begin
            spi_mosi = k[0];
            spi_sck  = 1'b1;
            tick(H);
            spi_sck  = 1'b0;
            tick(H);
            check("midreset_idle_busy", 32'(busy), 32'd0);
        end
        check("midreset_rx_valid_cnt", 32'(rxv_cnt), 32'd0);
        check("midreset_underrun_cnt", 32'(ufl_cnt), 32'd0);
        exp_rx_q.push_back(8'h69);
        spi_cs_n = 1'b0;
        frame_bits(8'h69, 8, 1'b1, m1);
        tick(SS + 4);
        $display("post-reset: master got %02h, rx_byte %02h", m1, rx_byte);
        check("postreset_miso_byte", 32'(m1), 32'h00);
        check("postreset_rx_byte", 32'(rx_byte), 32'h69);
        check("postreset_underrun_cnt", 32'(ufl_cnt), 32'd1);
        check("postreset_rx_valid_cnt", 32'(rxv_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, which sets the synchronizer depth on spi_sck, spi_cs_n and spi_mosi (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port spi_sck, input, 1 bit: SPI clock from the master, asynchronous to clk.
REQ-005 SHALL have port spi_cs_n, input, 1 bit: active-low chip select, asynchronous to clk.
REQ-006 SHALL have port spi_mosi, input, 1 bit: serial data from the master, asynchronous to clk.
REQ-007 SHALL have port spi_miso, output, 1 bit: serial data to the master.
REQ-008 SHALL have port spi_miso_oe, output, 1 bit: MISO output enable, high only while the slave is selected.
REQ-009 SHALL have port tx_byte, input, 8 bits: next byte to transmit.
REQ-010 SHALL have port tx_load, input, 1 bit: writes tx_byte into the holding register.
REQ-011 SHALL have port tx_ready, output, 1 bit: holding register empty.
REQ-012 SHALL have port rx_byte, output, 8 bits: last fully received byte.
REQ-013 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_byte updates.
REQ-014 SHALL have port tx_underrun, output, 1 bit: one-cycle pulse when a byte slot starts with the holding register empty.
REQ-015 SHALL have port busy, output, 1 bit: high in state ACTIVE.

Function
REQ-016 SHALL implement SPI Mode 0 (CPOL=0, CPHA=0), MSB-first, 8-bit frames; back-to-back bytes SHALL be allowed within one CS assertion.
REQ-017 SHALL pass sck, cs_n and mosi through SYNC_STAGES flops, with reset values 0, 1 and 0 respectively; edges SHALL be detected by comparing the last sync stage with one further delayed flop.
REQ-018 SHALL support SCK high and low phases of at least SYNC_STAGES+3 clk cycles each; behaviour at faster SCK is unspecified.
REQ-019 SHALL have two states: IDLE and ACTIVE.
REQ-020 IDLE -> ACTIVE on a synchronized cs_n falling edge: bit_cnt=0, shift_tx loaded from the holding register.
REQ-021 ACTIVE -> IDLE on a synchronized cs_n rising edge from any bit position: the partial rx byte SHALL be discarded, with no rx_valid and no underrun pulse.
REQ-022 On each shift_tx load, if the holding register is full it SHALL be consumed and tx_ready SHALL go to 1 the next cycle; if it is empty, 0x00 SHALL be loaded and tx_underrun SHALL pulse.
REQ-023 On a synchronized sck rising edge in ACTIVE: shift_rx <= {shift_rx[6:0], mosi_sync} and bit_cnt increments.
REQ-024 When bit_cnt goes 7->8, rx_byte SHALL be updated with the complete byte and rx_valid SHALL pulse in the same register update; rx_byte SHALL hold until the next complete byte.
REQ-025 On a synchronized sck falling edge in ACTIVE: if bit_cnt==8, shift_tx SHALL be reloaded (REQ-022) and bit_cnt cleared; otherwise shift_tx SHALL shift left by one.
REQ-026 spi_miso SHALL equal shift_tx[7] in ACTIVE and 0 in IDLE, and spi_miso_oe SHALL equal busy.
REQ-027 tx_load with tx_ready=1 SHALL capture tx_byte and clear tx_ready the next cycle; tx_load with tx_ready=0 SHALL be ignored.
REQ-028 tx_load in the same cycle as a consume SHALL be ignored, because tx_ready was 0 at that edge.
REQ-029 sck edges in IDLE SHALL be ignored.
REQ-030 A cs_n falling and a sck edge seen in the same cycle SHALL be treated as the cs_n edge only.

Reset
REQ-031 With rst_n=0 at a clk edge: state=IDLE, bit_cnt=0, shift_tx=0, shift_rx=0, holding register empty, tx_ready=1, rx_byte=0x00, rx_valid=0, tx_underrun=0, busy=0, spi_miso=0, spi_miso_oe=0, synchronizers per REQ-017.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no pulses; after release a new cs_n falling edge SHALL be required before ACTIVE is entered.

Structure
REQ-033 A shared spi_pkg SHALL hold the state encoding (IDLE, ACTIVE), SPI_BITS=8 and the synchronizer reset constants.
REQ-034 One sub-module, spi_sync_edge, SHALL be used: a synchronizer plus rise/fall detector with a reset-value parameter, instantiated three times.

Verification
REQ-035 Preload 0xA5; master (half-period 5 clk) sends 0x3C -> rx_byte=0x3C, one rx_valid pulse, master receives 0xA5, tx_underrun never pulses.
REQ-036 Two bytes in one CS: preload 0x11, load 0x22 after tx_ready rises; master sends 0xF0, 0x0F -> rx_valid pulses with 0xF0 then 0x0F, master receives 0x11 then 0x22.
REQ-037 No preload; master sends 0x55 -> tx_underrun pulses once at CS fall, master receives 0x00, rx_byte=0x55.
REQ-038 CS deasserted after 5 SCK rising edges -> no rx_valid, rx_byte keeps its prior value, busy=0 and spi_miso_oe=0 within SYNC_STAGES+2 clk.
REQ-039 tx_load while tx_ready=0 with value 0x99 -> ignored, and the originally loaded byte is transmitted.
REQ-040 rst_n low for 1 clk mid-byte -> all outputs at reset values, and SCK edges before the next CS fall are ignored.
